// File: rtl/pc_ir_unit.sv
// PC / OldPC / IR / memory-data / ALUOut holder for the multicycle RISC-V core, with branch resolution.
// Optional retired-fetch counter enabled by defining PC_IR_INSTRET_EN.
module pc_ir_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IRWrite,
  input  logic            PCUpdate,
  input  logic            beq,
  input  logic            bne,
  input  logic            blt,
  input  logic            bge,
  input  logic            Zero,
  input  logic            Negative,
  input  logic            Overflow,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] Result,
  input  logic [XLEN-1:0] ReadData,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] OldPC,
  output logic [31:0]     Instr,
  output logic [XLEN-1:0] Data,
  output logic [XLEN-1:0] ALUOut,
  output logic            PCWrite,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [31:0]     instret
);

  logic lt;

  // Signed less-than taken from the flags of the SUB performed in the branch cycle.
  assign lt      = Negative ^ Overflow;
  assign PCWrite = PCUpdate | (beq & Zero) | (bne & ~Zero) | (blt & lt) | (bge & ~lt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC <= RESET_PC;
    end else if (PCWrite) begin
      PC <= Result;
    end
  end

  // OldPC samples the pre-update PC, so fetch can write PC and IR on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      OldPC <= RESET_PC;
      Instr <= NOP_INSTR;
    end else if (IRWrite) begin
      OldPC <= PC;
      Instr <= ReadData[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Data   <= '0;
      ALUOut <= '0;
    end else begin
      Data   <= ReadData;
      ALUOut <= ALUResult;
    end
  end

  assign opcode = Instr[6:0];
  assign rd     = Instr[11:7];
  assign funct3 = Instr[14:12];
  assign rs1    = Instr[19:15];
  assign rs2    = Instr[24:20];
  assign funct7 = Instr[31:25];

`ifdef PC_IR_INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_q <= '0;
    end else if (IRWrite) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: doc/pc_ir_unit.md
Name: pc_ir_unit

Overview:
Architectural and non-architectural state holder for the multicycle RISC-V core. It sits between the main control FSM and the datapath.
- Holds PC, OldPC, the instruction register (IR), the memory-data register and the ALUOut register.
- Resolves branch conditions from the FSM's branch strobes and the ALU flags, and generates the PC write enable.
- Feeds opcode/funct3 back to the FSM and rs1/rs2/rd/funct7 to the register file and ALU decoder.

Parameters:
XLEN, 32, datapath width in bits
RESET_PC, 32'h0000_0000, PC and OldPC value after reset
NOP_INSTR, 32'h0000_0013, IR value after reset (addi x0,x0,0)

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
IRWrite  in  1  from FSM: capture fetched instruction and OldPC
PCUpdate  in  1  from FSM: unconditional PC write (fetch increment, jal)
beq  in  1  from FSM: branch-if-equal evaluation cycle
bne  in  1  from FSM: branch-if-not-equal evaluation cycle
blt  in  1  from FSM: branch-if-less-than (signed) evaluation cycle
bge  in  1  from FSM: branch-if-greater-or-equal (signed) evaluation cycle
Zero  in  1  ALU flag: result == 0
Negative  in  1  ALU flag: result[XLEN-1]
Overflow  in  1  ALU flag: signed overflow of subtraction
ALUResult  in  XLEN  combinational ALU output
Result  in  XLEN  ResultSrc mux output (next-PC source)
ReadData  in  XLEN  memory read data
PC  out  XLEN  current program counter
OldPC  out  XLEN  PC of the instruction held in IR
Instr  out  32  instruction register
Data  out  XLEN  memory-data register
ALUOut  out  XLEN  registered ALU result
PCWrite  out  1  combinational PC write enable (visible for debug and bench)
opcode  out  7  Instr[6:0]
funct3  out  3  Instr[14:12]
funct7  out  7  Instr[31:25]
rs1  out  5  Instr[19:15]
rs2  out  5  Instr[24:20]
rd  out  5  Instr[11:7]
instret  out  32  retired-fetch counter (see Optional Feature)

Behaviour:
- Reset (async, any time, including mid-instruction): PC=RESET_PC, OldPC=RESET_PC, Instr=NOP_INSTR, Data=0, ALUOut=0, instret=0. Reset dominates all enables.
- lt = Negative ^ Overflow (signed compare of SUB result).
- PCWrite = PCUpdate | (beq & Zero) | (bne & ~Zero) | (blt & lt) | (bge & ~lt). Purely combinational, no latency.
- PC: on edge with PCWrite=1, PC <= Result; otherwise PC holds.
- IR/OldPC: on edge with IRWrite=1, Instr <= ReadData[31:0] and OldPC <= PC (pre-update value). This applies even when PCWrite=1 on the same edge, which is the fetch state.
- Data: ReadData is registered every cycle, unconditionally.
- ALUOut: ALUResult is registered every cycle, unconditionally.
- Decoded fields: combinational slices of the registered Instr. They change only one cycle after IRWrite.
- Multiple branch strobes high at once: never driven by the FSM. The block's response is still the OR formula above, with no error flag.
- PCUpdate together with a branch strobe: PCUpdate wins, PCWrite=1.
- No strobe high: PC, OldPC and Instr hold. Data and ALUOut still track their inputs.
- PC arithmetic is done externally. Wrap at 2^XLEN is inherent in Result.

Optional Feature:
PC_IR_INSTRET_EN
- Defined: a 32-bit counter increments on every edge with IRWrite=1 (one per fetch). It wraps from 32'hFFFF_FFFF to 0 and is cleared by reset. instret drives the counter.
- Undefined: no counter is built and instret is tied to 0.

Test Plan:
1. Assert reset mid-run with PC=0x40 -> PC=0x0, OldPC=0x0, Instr=0x00000013, opcode=7'h13, Data=0, ALUOut=0 immediately, without waiting for a clock edge.
2. Fetch: PC=0x10, IRWrite=1, PCUpdate=1, ReadData=0x00A28263, Result=0x14 -> next cycle PC=0x14, OldPC=0x10, Instr=0x00A28263, opcode=7'h63, funct3=0, rs1=5, rs2=10.
3. beq=1 with Zero=1, Result=0x30 -> PCWrite=1 and PC=0x30. Same stimulus with Zero=0 -> PCWrite=0 and PC unchanged. bne with Zero=0 -> PC updated.
4. blt=1, Negative=0, Overflow=1 (e.g. 0x80000000 - 1) -> lt=1, PC updated. bge=1 with the same flags -> PC unchanged.
5. Only IRWrite=0 and all strobes low for 5 cycles while ReadData/ALUResult change -> PC, OldPC and Instr stable; Data and ALUOut follow their inputs with 1-cycle latency.
6. With PC_IR_INSTRET_EN defined, preload-by-run to 32'hFFFF_FFFF and issue one IRWrite -> instret=0. Without the macro, instret=0 after 10 fetches.
